// File: rtl/seq_nobi_subtractor.sv
// Multi-cycle a - b with no borrow input, CHUNK_WIDTH bits per clock, borrow rippled through a register.
// state | meaning: IDLE accept operands | CALC subtract chunk idx | DONE hold result until out_ready
module seq_nobi_subtractor #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  bo,
    output logic                  ov
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   diff_q, diff_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    borrow_q, borrow_d;
    logic                    bo_q, bo_d;
    logic                    ov_q, ov_d;

    logic [CHUNK_WIDTH-1:0]  a_chunk;
    logic [CHUNK_WIDTH-1:0]  b_chunk;
    logic [CHUNK_WIDTH:0]    sub_res;

    // Operates only on latched operands so live inputs never reach diff.
    always_comb begin
        a_chunk = a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
        b_chunk = b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
        sub_res = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_WIDTH{1'b0}}, borrow_q};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        bo_d      = bo_q;
        ov_d      = ov_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                diff_d[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = sub_res[CHUNK_WIDTH-1:0];
                borrow_d = sub_res[CHUNK_WIDTH];
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    bo_d    = sub_res[CHUNK_WIDTH];
                    ov_d    = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                              (sub_res[CHUNK_WIDTH-1] != a_q[DATA_WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            ov_q     <= ov_d;
        end
    end

    assign diff = diff_q;
    assign bo   = bo_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_seq_nobi_subtractor.sv
// Scoreboard bench for seq_nobi_subtractor: instances with CHUNK_WIDTH 8, 1 and 32.
module tb_seq_nobi_subtractor;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv   = '0;
    logic [2:0]  ordy = 3'b111;
    logic [31:0] a_s [3];
    logic [31:0] b_s [3];
    logic [2:0]  ir;
    logic [2:0]  ovv;
    logic [2:0]  bo_s;
    logic [2:0]  ovf_s;
    logic [31:0] diff_s [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc_cyc [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [31:0] ta [9];
    logic [31:0] tb [9];
    exp_t        te [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_nobi_subtractor #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
        .out_valid(ovv[0]), .out_ready(ordy[0]), .diff(diff_s[0]), .bo(bo_s[0]), .ov(ovf_s[0]));

    seq_nobi_subtractor #(.DATA_WIDTH(32), .CHUNK_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
        .out_valid(ovv[1]), .out_ready(ordy[1]), .diff(diff_s[1]), .bo(bo_s[1]), .ov(ovf_s[1]));

    seq_nobi_subtractor #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[2]), .b(b_s[2]),
        .out_valid(ovv[2]), .out_ready(ordy[2]), .diff(diff_s[2]), .bo(bo_s[2]), .ov(ovf_s[2]));

    function automatic exp_t model(logic [31:0] av, logic [31:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.bo = (av < bv);
        e.ov = (av[31] != bv[31]) && (e.d[31] != av[31]);
        return e;
    endfunction

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void push(int k, exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t pop(int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result handshake happens.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (rst) begin
                q0.delete();
                q1.delete();
                q2.delete();
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (ovv[k] && ordy[k]) begin
                        act = {diff_s[k], bo_s[k], ovf_s[k]};
                        checks++;
                        if (qsize(k) == 0) begin
                            errors++;
                            $display("FAIL sb%0d unexpected result: diff=0x%h bo=%0b ov=%0b",
                                     k, act.d, act.bo, act.ov);
                        end else begin
                            e = pop(k);
                            if (act !== e) begin
                                errors++;
                                $display("FAIL sb%0d result: got diff=0x%h bo=%0b ov=%0b, expected diff=0x%h bo=%0b ov=%0b",
                                         k, act.d, act.bo, act.ov, e.d, e.bo, e.ov);
                            end
                        end
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(int k, logic [31:0] av, logic [31:0] bv, exp_t e);
        int  n    = 0;
        bit  done = 1'b0;
        iv[k]  = 1'b1;
        a_s[k] = av;
        b_s[k] = bv;
        while (!done) begin
            @(negedge clk);
            if (ir[k]) begin
                push(k, e);
                acc_cyc[k] = cyc;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                checks++;
                errors++;
                $display("FAIL issue%0d: in_ready never seen, got timeout, expected accept", k);
                done = 1'b1;
            end
        end
        iv[k] = 1'b0;
    endtask

    task automatic wait_idle(int k);
        int n = 0;
        while (qsize(k) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (qsize(k) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain%0d: %0d results outstanding, expected 0", k, qsize(k));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(int k, int nops);
        logic [31:0] av;
        logic [31:0] bv;
        for (int i = 0; i < nops; i++) begin
            av = $urandom;
            bv = $urandom;
            if (i % 4 == 0) bv = av;
            if (i % 4 == 1) av = av & 32'hFF00_0000;
            issue(k, av, bv, model(av, bv));
        end
        wait_idle(k);
    endtask

    initial begin
        int n;
        int stalls;
        int prev_acc;

        ta[0] = 32'h0000_0005; tb[0] = 32'h0000_0003; te[0] = {32'h0000_0002, 1'b0, 1'b0};
        ta[1] = 32'h0000_0003; tb[1] = 32'h0000_0005; te[1] = {32'hFFFF_FFFE, 1'b1, 1'b0};
        ta[2] = 32'hFFFF_FFFF; tb[2] = 32'hFFFF_FFFF; te[2] = {32'h0000_0000, 1'b0, 1'b0};
        ta[3] = 32'h0100_0000; tb[3] = 32'h0000_0001; te[3] = {32'h00FF_FFFF, 1'b0, 1'b0};
        ta[4] = 32'h8000_0000; tb[4] = 32'h0000_0001; te[4] = {32'h7FFF_FFFF, 1'b0, 1'b1};
        ta[5] = 32'h0000_0010; tb[5] = 32'h0000_0020; te[5] = {32'hFFFF_FFF0, 1'b1, 1'b0};
        ta[6] = 32'h0000_0000; tb[6] = 32'h8000_0000; te[6] = {32'h8000_0000, 1'b1, 1'b1};
        ta[7] = 32'h7FFF_FFFF; tb[7] = 32'hFFFF_FFFF; te[7] = {32'h8000_0000, 1'b1, 1'b1};
        ta[8] = 32'h0000_0100; tb[8] = 32'h0000_00FF; te[8] = {32'h0000_0001, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            a_s[k] = '0;
            b_s[k] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", {29'd0, ir}, 32'h7);
        chk("reset out_valid", {29'd0, ovv}, 32'h0);
        chk("reset diff", diff_s[0], 32'h0);
        chk("reset bo/ov", {30'd0, bo_s[0], ovf_s[0]}, 32'h0);
        @(posedge clk);
        #1;

        // Latency from the accept edge to first out_valid.
        issue(0, ta[0], tb[0], te[0]);
        n = 0;
        while (!ovv[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 32'd5);
        wait_idle(0);

        // Back-to-back with in_valid and out_ready held high.
        prev_acc = 0;
        for (int i = 1; i < 9; i++) begin
            issue(0, ta[i], tb[i], te[i]);
            if (i > 1) chk("throughput spacing", acc_cyc[0] - prev_acc, 32'd6);
            prev_acc = acc_cyc[0];
        end
        wait_idle(0);

        // Backpressure with ignored operand pulses in CALC and DONE.
        ordy[0] = 1'b0;
        issue(0, 32'h1234_5678, 32'h1111_1111, {32'h0123_4567, 1'b0, 1'b0});
        stalls = 0;
        n = 0;
        while (stalls < 6 && n < 30) begin
            iv[0]  = (n % 2 == 0);
            a_s[0] = 32'hDEAD_BEEF;
            b_s[0] = 32'h0000_0001;
            @(negedge clk);
            chk("busy in_ready", {31'd0, ir[0]}, 32'h0);
            if (ovv[0]) begin
                stalls++;
                chk("stall diff", diff_s[0], 32'h0123_4567);
                chk("stall bo/ov", {30'd0, bo_s[0], ovf_s[0]}, 32'h0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall cycles", stalls, 32'd6);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release in_ready", {31'd0, ir[0]}, 32'h1);
        chk("release out_valid", {31'd0, ovv[0]}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("no queued op", {31'd0, ovv[0]}, 32'h0);
        @(posedge clk);
        #1;

        // Reset during the second CALC cycle.
        issue(0, 32'h0000_0005, 32'h0000_0003, te[0]);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset in_ready", {31'd0, ir[0]}, 32'h1);
        chk("midreset out_valid", {31'd0, ovv[0]}, 32'h0);
        chk("midreset diff", diff_s[0], 32'h0);
        chk("midreset bo/ov", {30'd0, bo_s[0], ovf_s[0]}, 32'h0);
        @(posedge clk);
        #1;
        issue(0, ta[5], tb[5], te[5]);
        wait_idle(0);

        // Reference regression on all chunk widths.
        fork
            rand_run(0, 1000);
            rand_run(1, 150);
            rand_run(2, 1000);
        join

        for (int k = 0; k < 3; k++) chk("final queue empty", qsize(k), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
